screen_filler_core: RTL and testbench

Frame-clear pixel generator. On one accepted start request it emits every pixel of a WIDTH×HEIGHT framebuffer once, in raster order, all in a single latched fill color and at far-plane depth. It sits in the renderer ahead of the triangle rasterizer. The render manager starts it at frame begin and muxes its stream into the shared depth-test/framebuffer write port, with depth compare disabled.

---
 rtl/screen_filler_core_pkg.sv | 14 +
 rtl/screen_filler_core_xy_scan_counter.sv | 53 +++++
 rtl/screen_filler_core.sv | 97 +++++++++
 tb/tb_screen_filler_core.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/screen_filler_core_pkg.sv
// Shared render types for the screen filler: 12-bit color, q16.16 depth and the fill FSM states.
package screen_filler_core_pkg;

  typedef logic [11:0] color12_t;
  typedef logic signed [31:0] q16_16_t;

  localparam q16_16_t DEPTH_FAR = 32'h7FFF_FFFF;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/screen_filler_core_xy_scan_counter.sv
// Raster-order x/y counter for a WIDTH x HEIGHT frame.
// Provides a last-pixel flag decoded from the registered coordinates.
module screen_filler_core_xy_scan_counter #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        advance_i,
  output logic [15:0] x_o,
  output logic [15:0] y_o,
  output logic        last_o
);

  localparam logic [15:0] XMAX = 16'(WIDTH - 1);
  localparam logic [15:0] YMAX = 16'(HEIGHT - 1);

  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;

  // Wrapping y on the final pixel leaves the counter at (0,0) for the next frame.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (advance_i) begin
      if (x_q == XMAX) begin
        x_d = '0;
        y_d = (y_q == YMAX) ? '0 : y_q + 16'd1;
      end else begin
        x_d = x_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == XMAX) && (y_q == YMAX);

endmodule

// File: rtl/screen_filler_core.sv
// Frame-clear pixel generator: one start emits every pixel of the frame in raster order.
// Optional out_depth port (constant far plane) enabled by SCREEN_FILLER_DEPTH_EN.
module screen_filler_core
  import screen_filler_core_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  color12_t    fill_color,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        busy,
  output logic [15:0] out_pixel_x,
  output logic [15:0] out_pixel_y,
  output color12_t    out_color,
`ifdef SCREEN_FILLER_DEPTH_EN
  output q16_16_t     out_depth,
`endif
  output logic        out_valid,
  input  logic        out_ready
);

  fill_state_e state_q;
  logic        busy_q;
  logic        out_valid_q;
  logic        in_ready_q;
  color12_t    color_q;

  logic        start;
  logic        advance;
  logic        last_pixel;

  assign start   = (state_q == IDLE) && in_valid;
  assign advance = (state_q == FILL) && out_ready;

  screen_filler_core_xy_scan_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (start),
    .advance_i(advance),
    .x_o      (out_pixel_x),
    .y_o      (out_pixel_y),
    .last_o   (last_pixel)
  );

  // Status outputs are registered alongside the state so no input reaches them combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      color_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q     <= FILL;
            color_q     <= fill_color;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b0;
          end
        end
        FILL: begin
          if (out_ready && last_pixel) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign out_color = color_q;

`ifdef SCREEN_FILLER_DEPTH_EN
  assign out_depth = DEPTH_FAR;
`endif

endmodule

// File: tb/tb_screen_filler_core.sv
// Directed bench for screen_filler_core on a 4x3 frame.
// Checks out_depth as well when SCREEN_FILLER_DEPTH_EN is defined.
module tb_screen_filler_core;

  localparam int W = 4;
  localparam int H = 3;
  localparam int NPIX = W * H;

  logic        clk;
  logic        rst;
  logic [11:0] fill_color;
  logic        in_valid;
  logic        in_ready;
  logic        busy;
  logic [15:0] out_pixel_x;
  logic [15:0] out_pixel_y;
  logic [11:0] out_color;
`ifdef SCREEN_FILLER_DEPTH_EN
  logic [31:0] out_depth;
`endif
  logic        out_valid;
  logic        out_ready;

  int compareCount;
  int mismatchCount;

  screen_filler_core #(
    .WIDTH (W),
    .HEIGHT(H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fill_color (fill_color),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .busy       (busy),
    .out_pixel_x(out_pixel_x),
    .out_pixel_y(out_pixel_y),
    .out_color  (out_color),
`ifdef SCREEN_FILLER_DEPTH_EN
    .out_depth  (out_depth),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  // Called on a negedge; issues a start there and follows the frame pixel by pixel.
  // stopAfter < NPIX leaves the frame unfinished after that many transfers.
  task automatic applyStimulus(input logic [11:0] color, input bit stall, input bit pulseMid, input int stopAfter);
    int k;
    int cycles;
    k = 0;
    cycles = 0;
    fill_color = color;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    checkOutput("in_ready_after_start", 32'(in_ready), 32'd0);
    while (k < stopAfter && cycles < 200) begin
      checkOutput("out_valid", 32'(out_valid), 32'd1);
      checkOutput("busy", 32'(busy), 32'd1);
      checkOutput("pixel_x", 32'(out_pixel_x), 32'(k % W));
      checkOutput("pixel_y", 32'(out_pixel_y), 32'(k / W));
      checkOutput("color", 32'(out_color), 32'(color));
`ifdef SCREEN_FILLER_DEPTH_EN
      checkOutput("depth", out_depth, 32'h7FFF_FFFF);
`endif
      out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (pulseMid && k == 5) begin
        in_valid   = 1'b1;
        fill_color = 12'h123;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_ready) k++;
      cycles++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("transfer_count", 32'(k), 32'(stopAfter));
    if (stopAfter == NPIX) checkIdle("frame_end");
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst        = 1'b1;
    fill_color = 12'h000;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    checkIdle("in_reset");
    rst = 1'b0;
    @(negedge clk);
    checkIdle("after_reset");
    checkOutput("reset_color", 32'(out_color), 32'd0);
    checkOutput("reset_x", 32'(out_pixel_x), 32'd0);

    $display("[TB] unstalled frame ABC");
    applyStimulus(12'hABC, 1'b0, 1'b0, NPIX);
    @(negedge clk);

    $display("[TB] stalled frame ABC");
    applyStimulus(12'hABC, 1'b1, 1'b0, NPIX);
    @(negedge clk);

    $display("[TB] mid-frame start ignored");
    applyStimulus(12'hABC, 1'b0, 1'b1, NPIX);
    repeat (2) @(negedge clk);
    checkIdle("after_ignored_start");

    $display("[TB] back-to-back frames");
    applyStimulus(12'hF00, 1'b0, 1'b0, NPIX);
    applyStimulus(12'h0F0, 1'b1, 1'b0, NPIX);

    $display("[TB] reset after fifth transfer");
    applyStimulus(12'h5A5, 1'b0, 1'b0, 5);
    rst = 1'b1;
    #1;
    checkIdle("async_reset");
    checkOutput("async_reset_x", 32'(out_pixel_x), 32'd0);
    checkOutput("async_reset_y", 32'(out_pixel_y), 32'd0);
    checkOutput("async_reset_color", 32'(out_color), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkIdle("post_reset_idle");
    applyStimulus(12'h3C3, 1'b0, 1'b0, NPIX);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
